// File: rtl/int_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : int_issue_queue
//  Purpose  : Age-ordered, compacting integer issue queue with CDB wakeup and
//             oldest-ready selection toward the integer ALU.
//  Option   : IQ_INT_SAME_CYCLE_WAKEUP_EN - operands matching the live CDB
//             broadcast count as ready and are forwarded from cdb_data.
//  Revision : 1.0 - initial release
// ============================================================================
module int_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_int_dispatch,
    input  logic                       disp_rs1_pend,
    input  logic [TAG_W-1:0]           disp_rs1_tag,
    input  logic [31:0]                disp_rs1_data,
    input  logic                       disp_rs2_pend,
    input  logic [TAG_W-1:0]           disp_rs2_tag,
    input  logic [31:0]                disp_rs2_data,
    input  logic [TAG_W-1:0]           disp_rd_tag,
    input  logic [6:0]                 disp_opcode,
    input  logic [2:0]                 disp_func3,
    input  logic [6:0]                 disp_func7,
    input  logic [31:0]                disp_imm,
    input  logic [31:0]                disp_br_addr,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [31:0]                cdb_data,
    output logic                       issueque_int_full,
    output logic                       issue_valid,
    input  logic                       alu_ready,
    output logic [31:0]                issue_rs1_data,
    output logic [31:0]                issue_rs2_data,
    output logic [TAG_W-1:0]           issue_rd_tag,
    output logic [6:0]                 issue_opcode,
    output logic [2:0]                 issue_func3,
    output logic [6:0]                 issue_func7,
    output logic [31:0]                issue_imm,
    output logic [31:0]                issue_br_addr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic             valid;
        logic             rs1_pend;
        logic [TAG_W-1:0] rs1_tag;
        logic [31:0]      rs1_data;
        logic             rs2_pend;
        logic [TAG_W-1:0] rs2_tag;
        logic [31:0]      rs2_data;
        logic [TAG_W-1:0] rd_tag;
        logic [6:0]       opcode;
        logic [2:0]       func3;
        logic [6:0]       func7;
        logic [31:0]      imm;
        logic [31:0]      br_addr;
    } entry_t;

    entry_t           r_q [DEPTH];
    logic [CW-1:0]    r_count;

    entry_t           w_wk  [DEPTH+1];
    entry_t           w_nxt [DEPTH];
    entry_t           w_new;
    logic [DEPTH-1:0] w_hit1;
    logic [DEPTH-1:0] w_hit2;
    logic [DEPTH-1:0] w_rdy;
    logic             w_any;
    logic [CW-1:0]    w_sel;
    logic             w_issue;
    logic             w_disp;
    logic [CW-1:0]    w_wr_idx;
    logic [CW-1:0]    w_count_nxt;
    logic             w_new_hit1;
    logic             w_new_hit2;

    assign issueque_int_full = (r_count == CW'(DEPTH));
    assign count             = r_count;

    // Per-entry CDB match, post-capture image and readiness.
    always_comb begin
        w_hit1 = '0;
        w_hit2 = '0;
        w_rdy  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit1[i] = cdb_valid && r_q[i].rs1_pend && (r_q[i].rs1_tag == cdb_tag);
            w_hit2[i] = cdb_valid && r_q[i].rs2_pend && (r_q[i].rs2_tag == cdb_tag);
            w_wk[i]   = r_q[i];
            if (w_hit1[i]) begin
                w_wk[i].rs1_pend = 1'b0;
                w_wk[i].rs1_data = cdb_data;
            end
            if (w_hit2[i]) begin
                w_wk[i].rs2_pend = 1'b0;
                w_wk[i].rs2_data = cdb_data;
            end
`ifdef IQ_INT_SAME_CYCLE_WAKEUP_EN
            w_rdy[i] = r_q[i].valid && (!r_q[i].rs1_pend || w_hit1[i])
                                    && (!r_q[i].rs2_pend || w_hit2[i]);
`else
            w_rdy[i] = r_q[i].valid && !r_q[i].rs1_pend && !r_q[i].rs2_pend;
`endif
        end
        // Empty slot shifted into the top position on an issue.
        w_wk[DEPTH] = '0;
    end

    // Oldest-ready select: scanning downward leaves the lowest index winning.
    always_comb begin
        w_any          = 1'b0;
        w_sel          = '0;
        issue_rs1_data = '0;
        issue_rs2_data = '0;
        issue_rd_tag   = '0;
        issue_opcode   = '0;
        issue_func3    = '0;
        issue_func7    = '0;
        issue_imm      = '0;
        issue_br_addr  = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (w_rdy[i]) begin
                w_any          = 1'b1;
                w_sel          = CW'(i);
`ifdef IQ_INT_SAME_CYCLE_WAKEUP_EN
                issue_rs1_data = r_q[i].rs1_pend ? cdb_data : r_q[i].rs1_data;
                issue_rs2_data = r_q[i].rs2_pend ? cdb_data : r_q[i].rs2_data;
`else
                issue_rs1_data = r_q[i].rs1_data;
                issue_rs2_data = r_q[i].rs2_data;
`endif
                issue_rd_tag   = r_q[i].rd_tag;
                issue_opcode   = r_q[i].opcode;
                issue_func3    = r_q[i].func3;
                issue_func7    = r_q[i].func7;
                issue_imm      = r_q[i].imm;
                issue_br_addr  = r_q[i].br_addr;
            end
        end
        issue_valid = w_any;
    end

    // Compaction on issue, then the dispatched entry lands at the new top.
    always_comb begin
        w_issue    = w_any && alu_ready;
        w_disp     = en_int_dispatch && !issueque_int_full;
        w_wr_idx   = w_issue ? (r_count - CW'(1)) : r_count;
        w_new_hit1 = cdb_valid && disp_rs1_pend && (disp_rs1_tag == cdb_tag);
        w_new_hit2 = cdb_valid && disp_rs2_pend && (disp_rs2_tag == cdb_tag);

        w_new          = '0;
        w_new.valid    = 1'b1;
        w_new.rs1_pend = disp_rs1_pend && !w_new_hit1;
        w_new.rs1_tag  = disp_rs1_tag;
        w_new.rs1_data = w_new_hit1 ? cdb_data : disp_rs1_data;
        w_new.rs2_pend = disp_rs2_pend && !w_new_hit2;
        w_new.rs2_tag  = disp_rs2_tag;
        w_new.rs2_data = w_new_hit2 ? cdb_data : disp_rs2_data;
        w_new.rd_tag   = disp_rd_tag;
        w_new.opcode   = disp_opcode;
        w_new.func3    = disp_func3;
        w_new.func7    = disp_func7;
        w_new.imm      = disp_imm;
        w_new.br_addr  = disp_br_addr;

        for (int i = 0; i < DEPTH; i++) begin
            w_nxt[i] = (w_issue && (CW'(i) >= w_sel)) ? w_wk[i+1] : w_wk[i];
            if (w_disp && (CW'(i) == w_wr_idx)) begin
                w_nxt[i] = w_new;
            end
        end

        w_count_nxt = r_count;
        if (w_disp && !w_issue) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_disp && w_issue) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= w_nxt[i];
            end
            r_count <= w_count_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_int_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_issue_queue
//  Purpose  : Directed and random stimulus for int_issue_queue against an
//             age-ordered list model of the queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_int_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, p1, p2, cv, ar;
    logic [5:0]  t1, t2, rdt, ct;
    logic [31:0] d1, d2, imm, br, cd;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;

    logic        issueque_int_full, issue_valid;
    logic [31:0] issue_rs1_data, issue_rs2_data, issue_imm, issue_br_addr;
    logic [5:0]  issue_rd_tag;
    logic [6:0]  issue_opcode, issue_func7;
    logic [2:0]  issue_func3;
    logic [2:0]  count;

    always #5 clk = ~clk;

    int_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .en_int_dispatch(en),
        .disp_rs1_pend(p1), .disp_rs1_tag(t1), .disp_rs1_data(d1),
        .disp_rs2_pend(p2), .disp_rs2_tag(t2), .disp_rs2_data(d2),
        .disp_rd_tag(rdt), .disp_opcode(opc), .disp_func3(f3), .disp_func7(f7),
        .disp_imm(imm), .disp_br_addr(br),
        .cdb_valid(cv), .cdb_tag(ct), .cdb_data(cd),
        .issueque_int_full(issueque_int_full), .issue_valid(issue_valid),
        .alu_ready(ar),
        .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
        .issue_rd_tag(issue_rd_tag), .issue_opcode(issue_opcode),
        .issue_func3(issue_func3), .issue_func7(issue_func7),
        .issue_imm(issue_imm), .issue_br_addr(issue_br_addr),
        .count(count)
    );

    typedef struct {
        bit          p1;
        logic [5:0]  t1;
        logic [31:0] d1;
        bit          p2;
        logic [5:0]  t2;
        logic [31:0] d2;
        logic [5:0]  rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] br;
    } op_t;

    op_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  m_sel  = -1;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit ready_now(input op_t e);
        bit s1;
        bit s2;
        s1 = !e.p1;
        s2 = !e.p2;
`ifdef IQ_INT_SAME_CYCLE_WAKEUP_EN
        s1 = s1 || (cv && e.t1 == ct);
        s2 = s2 || (cv && e.t2 == ct);
`endif
        return s1 && s2;
    endfunction

    task automatic check_outputs();
        logic [151:0] exp_v;
        op_t e;
        m_sel = -1;
        foreach (q[k]) if (m_sel < 0 && ready_now(q[k])) m_sel = k;
        exp_v = '0;
        if (m_sel >= 0) begin
            e = q[m_sel];
            exp_v = {1'b1, (e.p1 ? cd : e.d1), (e.p2 ? cd : e.d2), e.rd, e.op,
                     e.f3, e.f7, e.imm, e.br};
        end
        chk("issue", 160'({issue_valid, issue_rs1_data, issue_rs2_data, issue_rd_tag,
                           issue_opcode, issue_func3, issue_func7, issue_imm,
                           issue_br_addr}), 160'(exp_v));
        chk("count", 160'(count), 160'(q.size()));
        chk("full", 160'(issueque_int_full), 160'(q.size() == DEPTH));
    endtask

    // Wake every waiting operand, retire the chosen op, append the new one.
    task automatic model_edge();
        int  pre;
        bit  fire;
        op_t n;
        pre  = q.size();
        fire = (m_sel >= 0) && ar;
        if (cv) begin
            foreach (q[k]) begin
                if (q[k].p1 && q[k].t1 == ct) begin q[k].p1 = 0; q[k].d1 = cd; end
                if (q[k].p2 && q[k].t2 == ct) begin q[k].p2 = 0; q[k].d2 = cd; end
            end
        end
        if (fire) q.delete(m_sel);
        if (en && pre < DEPTH) begin
            n.p1 = p1; n.t1 = t1; n.d1 = d1;
            n.p2 = p2; n.t2 = t2; n.d2 = d2;
            n.rd = rdt; n.op = opc; n.f3 = f3; n.f7 = f7; n.imm = imm; n.br = br;
            if (cv && n.p1 && n.t1 == ct) begin n.p1 = 0; n.d1 = cd; end
            if (cv && n.p2 && n.t2 == ct) begin n.p2 = 0; n.d2 = cd; end
            q.push_back(n);
        end
    endtask

    task automatic cyc();
        #1;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
        en = 1'b0;
        cv = 1'b0;
    endtask

    task automatic disp(input bit a1, input logic [5:0] g1, input logic [31:0] v1,
                        input bit a2, input logic [5:0] g2, input logic [31:0] v2,
                        input logic [5:0] rd);
        en  = 1'b1;
        p1  = a1; t1 = g1; d1 = v1;
        p2  = a2; t2 = g2; d2 = v2;
        rdt = rd;
        opc = 7'($urandom);
        f3  = 3'($urandom);
        f7  = 7'($urandom);
        imm = $urandom;
        br  = $urandom;
    endtask

    initial begin
        rst = 1'b0; en = 0; p1 = 0; p2 = 0; cv = 0; ar = 0;
        t1 = 0; t2 = 0; rdt = 0; ct = 0; d1 = 0; d2 = 0; imm = 0; br = 0; cd = 0;
        opc = 0; f7 = 0; f3 = 0;
        @(posedge clk); #1;
        chk("rst_state", 160'({count, issueque_int_full, issue_valid, issue_rs1_data}), 160'(0));
        rst = 1'b1;

        // Asynchronous reset with three ops queued
        for (int k = 0; k < 3; k++) begin
            disp(0, 0, 32'(k), 0, 0, 1, 6'(k));
            cyc();
        end
        #1 chk("pre_rst_count", 160'(count), 160'(3));
        rst = 1'b0;
        #1 chk("async_rst", 160'({count, issueque_int_full, issue_valid}), 160'(0));
        q.delete();
        #1 rst = 1'b1;

        // Ready dispatch
        ar = 1'b1;
        disp(0, 0, 5, 0, 0, 7, 9);
        cyc();
        #1 chk("ready_issue", 160'({issue_valid, issue_rs1_data, issue_rd_tag}), 160'({1'b1, 32'd5, 6'd9}));
        cyc();
        #1 chk("ready_drain", 160'(count), 160'(0));

        // Wakeup
        ar = 1'b0;
        disp(1, 12, 0, 0, 0, 3, 13);
        cyc();
        #1 chk("wait_pend", 160'(issue_valid), 160'(0));
        cv = 1'b1; ct = 12; cd = 32'hDEAD;
        cyc();
        #1 chk("wakeup", 160'({issue_valid, issue_rs1_data}), 160'({1'b1, 32'hDEAD}));
        ar = 1'b1;
        cyc();

        // Full and drop
        ar = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(0, 0, 32'(k), 0, 0, 0, 6'(20 + k));
            cyc();
        end
        #1 chk("full", 160'({issueque_int_full, count}), 160'({1'b1, 3'd4}));
        disp(0, 0, 0, 0, 0, 0, 24);
        cyc();
        #1 chk("drop", 160'(count), 160'(4));
        ar = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("order", 160'(issue_rd_tag), 160'(20 + k));
            cyc();
        end

        // Age order
        ar = 1'b0;
        disp(1, 3, 0, 0, 0, 1, 30);
        cyc();
        disp(0, 0, 2, 0, 0, 3, 31);
        cyc();
        #1 chk("age_first", 160'(issue_rd_tag), 160'(31));
        ar = 1'b1;
        cyc();
        ar = 1'b0; cv = 1'b1; ct = 3; cd = 32'h1234_5678;
        cyc();
        #1 chk("age_second", 160'({issue_valid, issue_rd_tag, issue_rs1_data, count}),
               160'({1'b1, 6'd30, 32'h1234_5678, 3'd1}));
        ar = 1'b1;
        cyc();

        // Dispatch, issue and CDB at one edge with two ops queued
        ar = 1'b0;
        disp(1, 5, 0, 0, 0, 1, 40);
        cyc();
        disp(0, 0, 2, 0, 0, 3, 41);
        cyc();
        ar = 1'b1; cv = 1'b1; ct = 5; cd = 32'hCAFE;
        disp(0, 0, 4, 0, 0, 5, 42);
        cyc();
        ar = 1'b0;
        #1 chk("simul_count", 160'(count), 160'(2));
`ifndef IQ_INT_SAME_CYCLE_WAKEUP_EN
        chk("simul_capture", 160'({issue_rd_tag, issue_rs1_data}), 160'({6'd40, 32'hCAFE}));
        ar = 1'b1;
        cyc();
        #1 chk("simul_new_top", 160'(issue_rd_tag), 160'(42));
`else
        chk("simul_fwd_left", 160'(issue_rd_tag), 160'(41));
`endif
        ar = 1'b1;
        cyc();
        cyc();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) != 0)
                disp(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                     1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), $urandom,
                     6'($urandom));
            ar = ($urandom_range(0, 3) != 0);
            cv = 1'($urandom_range(0, 1));
            ct = 6'($urandom_range(0, 7));
            cd = $urandom;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Integer issue queue: the consumer side of the dispatcher's integer-queue write interface (en_int_dispatch plus the int_queue_data packet), returning issueque_int_full.
- Buffers renamed integer and branch ops and snoops the CDB to wake up pending operands.
- Issues the oldest ready entry to the integer ALU over a valid/ready handshake.
- The queue is age-ordered and compacting: entry 0 is always the oldest.

Parameters:
DEPTH, 4, number of queue entries (2..16).
TAG_W, 6, rename-tag width (matches the tag FIFO).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset (clears the queue when 0).
en_int_dispatch  in  1  dispatcher write strobe.
disp_rs1_pend  in  1  1 = rs1 waits on disp_rs1_tag; 0 = disp_rs1_data is valid.
disp_rs1_tag  in  TAG_W  rs1 producer tag.
disp_rs1_data  in  32  rs1 value.
disp_rs2_pend  in  1  same meaning as disp_rs1_pend, for rs2.
disp_rs2_tag  in  TAG_W  rs2 producer tag.
disp_rs2_data  in  32  rs2 value.
disp_rd_tag  in  TAG_W  destination tag.
disp_opcode  in  7  opcode.
disp_func3  in  3  func3.
disp_func7  in  7  func7.
disp_imm  in  32  immediate.
disp_br_addr  in  32  branch/jump target.
cdb_valid  in  1  CDB broadcast valid.
cdb_tag  in  TAG_W  CDB tag.
cdb_data  in  32  CDB value.
issueque_int_full  out  1  queue full; the dispatcher must not write.
issue_valid  out  1  an issuable entry is presented.
alu_ready  in  1  ALU accepts the presented entry.
issue_rs1_data  out  32  issued operand 1.
issue_rs2_data  out  32  issued operand 2.
issue_rd_tag  out  TAG_W  issued destination tag.
issue_opcode  out  7  issued opcode.
issue_func3  out  3  issued func3.
issue_func7  out  7  issued func7.
issue_imm  out  32  issued immediate.
issue_br_addr  out  32  issued branch target.
count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - All entry valid bits, count and issueque_int_full clear to 0.
  - issue_valid = 0; issue_* data = 0.
- Entry fields: valid, rs1_pend, rs1_tag, rs1_data, rs2_pend, rs2_tag, rs2_data, plus the payload fields.
- Ready condition: an entry is ready when valid and !rs1_pend and !rs2_pend.
- issueque_int_full = (count == DEPTH), derived from registered state only.
- Dispatch:
  - On a clock edge with en_int_dispatch=1 and full=0, the packet is written at index count, or at count-1 if an issue is also completing that edge.
  - If en_int_dispatch=1 while full=1, the write is dropped and count is unchanged, even if an issue completes in the same cycle.
- Dispatch-time wakeup: if cdb_valid and an incoming operand is pending with tag == cdb_tag, that operand is stored with pend=0 and data=cdb_data.
- CDB wakeup: each edge, every valid entry with a pending operand whose tag == cdb_tag (and cdb_valid=1) captures cdb_data and clears pend. rs1 and rs2 are checked independently; both may wake in the same cycle.
- Select (combinational): issue_valid = 1 when any ready entry exists; issue_* show the lowest-index ready entry. issue_* = 0 when issue_valid = 0.
- Issue completion:
  - Occurs when issue_valid & alu_ready are both high at an edge.
  - The selected entry is removed, entries above it shift down one index (preserving age order, with any CDB capture applied in the same edge), and count decrements.
- Simultaneous dispatch and issue: count unchanged; the new entry lands at the new top.
- Hold: while issue_valid=1 and alu_ready=0, the presented entry and outputs stay stable, unless an older entry wakes up; the oldest ready entry always wins.
- Latency: dispatch at edge N; earliest issue_valid is in the cycle after edge N; issue completes at edge N+1.
- CDB tag 0 is not special; a match requires cdb_valid=1.

Optional Feature:
- Macro: IQ_INT_SAME_CYCLE_WAKEUP_EN.
- Defined: the ready condition also counts an operand as ready when it is pending with tag == cdb_tag and cdb_valid=1 in the current cycle. Such an entry may issue in that same cycle, and issue_rsX_data is forwarded from cdb_data.
- Undefined: a woken entry becomes issuable the cycle after the broadcast.

Test Plan:
1. Reset: rst=0 mid-operation with count=3 -> count=0, full=0, issue_valid=0 immediately (asynchronously).
2. Ready dispatch: dispatch with both pend=0, rs1_data=5, rs2_data=7, rd_tag=9, alu_ready=1 -> next cycle issue_valid=1, issue_rs1_data=5, issue_rd_tag=9; count returns to 0 after that edge.
3. Wakeup:
   - Dispatch with rs1_pend=1, rs1_tag=12; issue_valid stays 0.
   - Apply cdb_valid=1, cdb_tag=12, cdb_data=0xDEAD -> the following cycle issue_valid=1, issue_rs1_data=0xDEAD.
   - With the macro defined, issue_valid=1 in the broadcast cycle itself.
4. Full: DEPTH=4, alu_ready=0, four dispatches -> full=1. A fifth dispatch is dropped (count stays 4). Raise alu_ready -> the entries issue in dispatch order.
5. Age order: entry0 pending on tag 3, entry1 ready -> entry1 issues first. Then a CDB with tag 3 -> entry0 issues; entries compact.
6. Simultaneous events at count=2: dispatch, issue, and a CDB matching the pending entry all at one edge -> count=2, the matched entry captures data, and the new entry sits at index 1.
